// File: rtl/m_axil_init_seq.sv
// AXI4-Lite master that replays a constant {addr,data} table into a register slave after START.
// Each entry can be read back and compared. The first failing entry and its cause are latched.
module m_axil_init_seq #(
  parameter int ADDR_WIDTH  = 6,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 4,
  parameter logic [NUM_ENTRIES*(ADDR_WIDTH+DATA_WIDTH)-1:0] INIT_TABLE = '0,
  parameter bit VERIFY      = 1'b1,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                  ACLK,
  input  logic                  ARESET,
  input  logic                  START,
  output logic                  BUSY,
  output logic                  DONE,
  output logic                  ERROR,
  output logic [7:0]            ERR_IDX,
  output logic [1:0]            ERR_CODE,
  output logic [2:0]            DBG_STATE,
  output logic [ADDR_WIDTH-1:0] AWADDR,
  output logic                  AWVALID,
  input  logic                  AWREADY,
  output logic [DATA_WIDTH-1:0] WDATA,
  output logic [3:0]            WSTRB,
  output logic                  WVALID,
  input  logic                  WREADY,
  input  logic [1:0]            BRESP,
  input  logic                  BVALID,
  output logic                  BREADY,
  output logic [ADDR_WIDTH-1:0] ARADDR,
  output logic                  ARVALID,
  input  logic                  ARREADY,
  input  logic [DATA_WIDTH-1:0] RDATA,
  input  logic [1:0]            RRESP,
  input  logic                  RVALID,
  output logic                  RREADY
);

  // Handshakes: a VALID (or our READY) rises on state entry, holds with a stable registered
  // payload until its partner samples high on a clock edge, and drops in the following cycle.
  localparam int EW = ADDR_WIDTH + DATA_WIDTH;
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [EW-1:0] ENTRY0 = INIT_TABLE[EW-1:0];

  typedef enum logic [2:0] {
    S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_NEXT, S_FIN
  } state_t;

  state_t                r_state;
  logic [7:0]            r_idx;
  logic [TW-1:0]         r_wait;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_error;
  logic [7:0]            r_err_idx;
  logic [1:0]            r_err_code;
  logic [ADDR_WIDTH-1:0] r_awaddr;
  logic [ADDR_WIDTH-1:0] r_araddr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_arvalid;
  logic                  r_rready;

  logic [7:0]            w_next_idx;
  logic [EW-1:0]         w_next_entry;
  logic                  w_tmo;
  logic                  w_last;

  assign w_next_idx = r_idx + 8'd1;
  assign w_last     = (r_idx == 8'(NUM_ENTRIES - 1));
  assign w_tmo      = (TIMEOUT_CYC != 0) && (r_wait == TW'(TIMEOUT_CYC - 1));

  always_comb begin
    w_next_entry = '0;
    for (int k = 0; k < NUM_ENTRIES; k++) begin
      if (w_next_idx == 8'(k)) w_next_entry = INIT_TABLE[k*EW +: EW];
    end
  end

  // Abort the sequence: drop every handshake signal and latch the failing entry.
  task automatic t_abort(input logic [1:0] code);
    r_awvalid  <= 1'b0;
    r_wvalid   <= 1'b0;
    r_bready   <= 1'b0;
    r_arvalid  <= 1'b0;
    r_rready   <= 1'b0;
    r_busy     <= 1'b0;
    r_done     <= 1'b1;
    r_error    <= 1'b1;
    r_err_idx  <= r_idx;
    r_err_code <= code;
    r_state    <= S_FIN;
  endtask

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state    <= S_IDLE;
      r_idx      <= '0;
      r_wait     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_error    <= 1'b0;
      r_err_idx  <= '0;
      r_err_code <= '0;
      r_awaddr   <= '0;
      r_araddr   <= '0;
      r_wdata    <= '0;
      r_awvalid  <= 1'b0;
      r_wvalid   <= 1'b0;
      r_bready   <= 1'b0;
      r_arvalid  <= 1'b0;
      r_rready   <= 1'b0;
    end else begin
      r_wait <= r_wait + TW'(1);
      case (r_state)
        S_IDLE: begin
          if (START) begin
            r_state    <= S_AW;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
            r_err_idx  <= '0;
            r_err_code <= '0;
            r_idx      <= '0;
            r_awaddr   <= ENTRY0[EW-1 -: ADDR_WIDTH];
            r_wdata    <= ENTRY0[DATA_WIDTH-1:0];
            r_awvalid  <= 1'b1;
            r_wait     <= '0;
          end
        end
        S_AW: begin
          if (AWREADY) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b1;
            r_wait    <= '0;
            r_state   <= S_W;
          end else if (w_tmo) begin
            t_abort(2'b11);
          end
        end
        S_W: begin
          if (WREADY) begin
            r_wvalid <= 1'b0;
            r_bready <= 1'b1;
            r_wait   <= '0;
            r_state  <= S_B;
          end else if (w_tmo) begin
            t_abort(2'b11);
          end
        end
        S_B: begin
          if (BVALID) begin
            r_bready <= 1'b0;
            r_wait   <= '0;
            if (BRESP != 2'b00) begin
              t_abort(2'b01);
            end else if (VERIFY) begin
              r_araddr  <= r_awaddr;
              r_arvalid <= 1'b1;
              r_state   <= S_AR;
            end else begin
              r_state <= S_NEXT;
            end
          end else if (w_tmo) begin
            t_abort(2'b11);
          end
        end
        S_AR: begin
          if (ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_wait    <= '0;
            r_state   <= S_R;
          end else if (w_tmo) begin
            t_abort(2'b11);
          end
        end
        S_R: begin
          // RREADY is held for the whole state; the slave waits for it before raising RVALID.
          if (RVALID) begin
            r_rready <= 1'b0;
            r_wait   <= '0;
            if (RRESP != 2'b00)        t_abort(2'b01);
            else if (RDATA != r_wdata) t_abort(2'b10);
            else                       r_state <= S_NEXT;
          end else if (w_tmo) begin
            t_abort(2'b11);
          end
        end
        S_NEXT: begin
          r_wait <= '0;
          if (w_last) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_idx     <= w_next_idx;
            r_awaddr  <= w_next_entry[EW-1 -: ADDR_WIDTH];
            r_wdata   <= w_next_entry[DATA_WIDTH-1:0];
            r_awvalid <= 1'b1;
            r_state   <= S_AW;
          end
        end
        S_FIN:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign BUSY      = r_busy;
  assign DONE      = r_done;
  assign ERROR     = r_error;
  assign ERR_IDX   = r_err_idx;
  assign ERR_CODE  = r_err_code;
  assign DBG_STATE = r_state;
  assign AWADDR    = r_awaddr;
  assign AWVALID   = r_awvalid;
  assign WDATA     = r_wdata;
  assign WSTRB     = 4'hF;
  assign WVALID    = r_wvalid;
  assign BREADY    = r_bready;
  assign ARADDR    = r_araddr;
  assign ARVALID   = r_arvalid;
  assign RREADY    = r_rready;

endmodule

// File: tb/tb_m_axil_init_seq.sv
// Bench for m_axil_init_seq: behavioural 16x32 AXI-Lite slave with fault injection, a transaction
// model of the expected write/read sequence, and a per-cycle protocol/scoreboard checker.
`timescale 1ns/1ps
module tb_m_axil_init_seq;
  localparam int AW  = 6;
  localparam int DW  = 32;
  localparam int NE  = 3;
  localparam int TMO = 8;
  localparam logic [AW-1:0] T_ADDR [NE] = '{6'h00, 6'h04, 6'h3C};
  localparam logic [DW-1:0] T_DATA [NE] = '{32'h11111111, 32'h22222222, 32'hDEADBEEF};
  localparam logic [NE*(AW+DW)-1:0] TABLE =
    {6'h3C, 32'hDEADBEEF, 6'h04, 32'h22222222, 6'h00, 32'h11111111};

  logic clk;
  logic ARESET, START, BUSY, DONE, ERROR;
  logic [7:0] ERR_IDX;
  logic [1:0] ERR_CODE;
  logic [2:0] DBG_STATE;
  logic [AW-1:0] AWADDR, ARADDR;
  logic [DW-1:0] WDATA, RDATA;
  logic [3:0] WSTRB;
  logic AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY, ARVALID, ARREADY, RVALID, RREADY;
  logic [1:0] BRESP, RRESP;

  m_axil_init_seq #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_ENTRIES(NE), .INIT_TABLE(TABLE),
    .VERIFY(1'b1), .TIMEOUT_CYC(TMO)
  ) dut (
    .ACLK(clk), .ARESET(ARESET), .START(START), .BUSY(BUSY), .DONE(DONE), .ERROR(ERROR),
    .ERR_IDX(ERR_IDX), .ERR_CODE(ERR_CODE), .DBG_STATE(DBG_STATE),
    .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY)
  );

  // Clock / watchdog
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave controls and state
  logic [31:0] mem [16];
  bit bp, hold_aw, inj_b, inj_r, exp_timeout;
  logic [AW-1:0] bad_b_addr = 6'h04;
  logic [AW-1:0] bad_r_addr = 6'h3C;
  bit s_aw_got, s_b_pend, s_ar_got;
  logic [AW-1:0] s_aw_addr, s_ar_addr;
  logic [1:0] s_bresp;
  int s_b_dly, s_r_dly, s_aw_wait, s_w_wait, s_ar_wait;
  int ar_hs_cnt;

  // Model: expected transaction queues and outcome
  logic [AW-1:0] exp_aw_q[$];
  logic [DW-1:0] exp_w_q[$];
  logic [AW-1:0] exp_ar_q[$];
  bit e_err;
  logic [7:0] e_idx;
  logic [1:0] e_code;

  task automatic build_model();
    exp_aw_q.delete();
    exp_w_q.delete();
    exp_ar_q.delete();
    e_err = 1'b0;
    e_idx = 8'd0;
    e_code = 2'b00;
    if (hold_aw) begin
      e_err = 1'b1;
      e_code = 2'b11;
      return;
    end
    for (int k = 0; k < NE; k++) begin
      exp_aw_q.push_back(T_ADDR[k]);
      exp_w_q.push_back(T_DATA[k]);
      if (inj_b && T_ADDR[k] == bad_b_addr) begin
        e_err = 1'b1; e_code = 2'b01; e_idx = 8'(k);
        return;
      end
      exp_ar_q.push_back(T_ADDR[k]);
      if (inj_r && T_ADDR[k] == bad_r_addr) begin
        e_err = 1'b1; e_code = 2'b10; e_idx = 8'(k);
        return;
      end
    end
  endtask

  // Slave: drives at negedge, records the handshakes of the coming edge just before it
  initial begin
    AWREADY = 0; WREADY = 0; BVALID = 0; BRESP = 0; ARREADY = 0; RVALID = 0; RDATA = 0; RRESP = 0;
    s_aw_got = 0; s_b_pend = 0; s_ar_got = 0; s_aw_addr = 0; s_ar_addr = 0; s_bresp = 0;
    s_b_dly = 0; s_r_dly = 0; s_aw_wait = 0; s_w_wait = 0; s_ar_wait = 0; ar_hs_cnt = 0;
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    forever begin
      @(negedge clk);
      AWREADY = !s_aw_got && !hold_aw && (!bp || s_aw_wait >= 3 || $urandom_range(0, 1) == 1);
      WREADY  = s_aw_got && !s_b_pend && (!bp || s_w_wait >= 3 || $urandom_range(0, 1) == 1);
      BVALID  = s_b_pend && (s_b_dly == 0);
      BRESP   = BVALID ? s_bresp : 2'b00;
      ARREADY = !s_ar_got && (!bp || s_ar_wait >= 3 || $urandom_range(0, 1) == 1);
      RVALID  = s_ar_got && RREADY && (s_r_dly == 0);
      RDATA   = RVALID ? (mem[s_ar_addr[5:2]] ^ {31'b0, (inj_r && s_ar_addr == bad_r_addr)}) : '0;
      RRESP   = 2'b00;
      #4;
      if (ARESET) begin
        s_aw_got = 0; s_b_pend = 0; s_ar_got = 0; s_b_dly = 0; s_r_dly = 0;
        s_aw_wait = 0; s_w_wait = 0; s_ar_wait = 0;
      end else begin
        if (WVALID && WREADY) begin
          s_bresp = (inj_b && s_aw_addr == bad_b_addr) ? 2'b10 : 2'b00;
          if (s_bresp == 2'b00) mem[s_aw_addr[5:2]] = WDATA;
          s_aw_got = 0; s_b_pend = 1; s_w_wait = 0;
          s_b_dly = bp ? $urandom_range(0, 3) : 0;
        end else if (WVALID) s_w_wait++;
        if (AWVALID && AWREADY) begin
          s_aw_got = 1; s_aw_addr = AWADDR; s_aw_wait = 0;
        end else if (AWVALID) s_aw_wait++;
        if (BVALID && BREADY) s_b_pend = 0;
        else if (s_b_pend && s_b_dly > 0) s_b_dly--;
        if (RVALID && RREADY) s_ar_got = 0;
        else if (s_ar_got && RREADY && s_r_dly > 0) s_r_dly--;
        if (ARVALID && ARREADY) begin
          s_ar_got = 1; s_ar_addr = ARADDR; s_ar_wait = 0; ar_hs_cnt++;
          s_r_dly = bp ? $urandom_range(0, 3) : 0;
        end else if (ARVALID) s_ar_wait++;
      end
    end
  end

  // Scoreboard / protocol checker, sampled 1ns before each rising edge
  initial begin
    logic p_awv, p_awr, p_wv, p_wr, p_arv, p_arr, p_br, p_bv, p_rr, p_rv, p_rst;
    logic [AW-1:0] p_awaddr, p_araddr;
    logic [DW-1:0] p_wdata;
    bit aw_open;
    p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0; p_arv = 0; p_arr = 0;
    p_br = 0; p_bv = 0; p_rr = 0; p_rv = 0; p_rst = 1;
    p_awaddr = 0; p_araddr = 0; p_wdata = 0; aw_open = 0;
    forever begin
      @(negedge clk);
      #4;
      if (!ARESET && !p_rst) begin
        if (p_awv && !p_awr) begin
          if (AWVALID) chk("aw_addr_stable", AWADDR, p_awaddr);
          else if (!exp_timeout) chk("aw_valid_hold", AWVALID, 1'b1);
        end
        if (p_wv && !p_wr) begin
          if (WVALID) chk("w_data_stable", WDATA, p_wdata);
          else if (!exp_timeout) chk("w_valid_hold", WVALID, 1'b1);
        end
        if (p_arv && !p_arr) begin
          if (ARVALID) chk("ar_addr_stable", ARADDR, p_araddr);
          else if (!exp_timeout) chk("ar_valid_hold", ARVALID, 1'b1);
        end
        if (p_br && !p_bv && !exp_timeout) chk("bready_hold", BREADY, 1'b1);
        if (p_rr && !p_rv && !exp_timeout) chk("rready_hold", RREADY, 1'b1);
      end
      if (ARESET) aw_open = 0;
      else begin
        if (WVALID) begin
          chk("wstrb", WSTRB, 4'hF);
          chk("w_after_aw", aw_open, 1'b1);
        end
        if (WVALID && WREADY) begin
          chk("w_expected", 32'(exp_w_q.size() != 0), 32'd1);
          if (exp_w_q.size() != 0) chk("wdata", WDATA, exp_w_q.pop_front());
          aw_open = 0;
        end
        if (AWVALID && AWREADY) begin
          chk("aw_expected", 32'(exp_aw_q.size() != 0), 32'd1);
          if (exp_aw_q.size() != 0) chk("awaddr", AWADDR, exp_aw_q.pop_front());
          aw_open = 1;
        end
        if (ARVALID && ARREADY) begin
          chk("ar_expected", 32'(exp_ar_q.size() != 0), 32'd1);
          if (exp_ar_q.size() != 0) chk("araddr", ARADDR, exp_ar_q.pop_front());
        end
      end
      p_awv = AWVALID; p_awr = AWREADY; p_wv = WVALID; p_wr = WREADY;
      p_arv = ARVALID; p_arr = ARREADY; p_br = BREADY; p_bv = BVALID;
      p_rr = RREADY; p_rv = RVALID; p_rst = ARESET;
      p_awaddr = AWADDR; p_araddr = ARADDR; p_wdata = WDATA;
    end
  end

  // Driver tasks (called at a falling edge)
  task automatic run_seq(input bit mid_start, output int cyc, output int aw_hi);
    build_model();
    ar_hs_cnt = 0;
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    chk("busy_after_start", BUSY, 1'b1);
    cyc = 0;
    aw_hi = 0;
    while (!DONE && cyc < 2000) begin
      if (AWVALID) aw_hi++;
      START = mid_start && (cyc == 5);
      cyc++;
      @(negedge clk);
    end
    START = 1'b0;
    chk("done_seen", DONE, 1'b1);
    chk("busy_at_done", BUSY, 1'b0);
    chk("error_flag", ERROR, e_err);
    if (e_err) begin
      chk("err_idx", ERR_IDX, e_idx);
      chk("err_code", ERR_CODE, e_code);
    end
    chk("aw_left", exp_aw_q.size(), 0);
    chk("w_left", exp_w_q.size(), 0);
    chk("ar_left", exp_ar_q.size(), 0);
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
  endtask

  task automatic check_mem(input string tag);
    chk({tag, "_reg0"}, mem[0], 32'h11111111);
    chk({tag, "_reg1"}, mem[1], 32'h22222222);
    chk({tag, "_reg15"}, mem[15], 32'hDEADBEEF);
  endtask

  int cyc, aw_hi;

  initial begin
    START = 0; ARESET = 1; bp = 0; hold_aw = 0; inj_b = 0; inj_r = 0; exp_timeout = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_done", DONE, 1'b0);
    chk("rst_error", ERROR, 1'b0);
    chk("rst_err_idx", ERR_IDX, 8'd0);
    chk("rst_err_code", ERR_CODE, 2'b00);
    chk("rst_state", DBG_STATE, 3'd0);
    chk("rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
    ARESET = 0;
    @(negedge clk);

    // T1: clean run, extra START mid-sequence, START in the FIN cycle
    run_seq(1'b1, cyc, aw_hi);
    chk("t1_latency", cyc, 18);
    chk("t1_ar_count", ar_hs_cnt, 3);
    check_mem("t1");
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    chk("t1_fin_start_dropped_busy", BUSY, 1'b0);
    chk("t1_fin_start_dropped_done", DONE, 1'b1);
    @(negedge clk);

    // T2: BRESP error on entry 1
    inj_b = 1;
    run_seq(1'b0, cyc, aw_hi);
    chk("t2_err_code", ERR_CODE, 2'b01);
    chk("t2_err_idx", ERR_IDX, 8'd1);
    chk("t2_ar_count", ar_hs_cnt, 1);
    inj_b = 0;
    @(negedge clk);

    // T3: corrupted readback on entry 2
    inj_r = 1;
    run_seq(1'b0, cyc, aw_hi);
    chk("t3_err_code", ERR_CODE, 2'b10);
    chk("t3_err_idx", ERR_IDX, 8'd2);
    inj_r = 0;
    @(negedge clk);

    // T4: AWREADY stuck low -> timeout
    hold_aw = 1; exp_timeout = 1;
    run_seq(1'b0, cyc, aw_hi);
    chk("t4_awvalid_cycles", aw_hi, 8);
    chk("t4_err_code", ERR_CODE, 2'b11);
    chk("t4_err_idx", ERR_IDX, 8'd0);
    @(negedge clk);
    hold_aw = 0; exp_timeout = 0;
    @(negedge clk);

    // T5: random backpressure on every channel
    bp = 1;
    for (int r = 0; r < 3; r++) begin
      clear_mem();
      run_seq(1'b0, cyc, aw_hi);
      check_mem("t5");
      @(negedge clk);
    end
    bp = 0;

    // T6: reset during the W phase of entry 1, then replay
    clear_mem();
    build_model();
    START = 1'b1;
    @(negedge clk);
    START = 1'b0;
    cyc = 0;
    while (!(WVALID && exp_aw_q.size() == 1) && cyc < 200) begin
      cyc++;
      @(negedge clk);
    end
    chk("t6_reached_w1", WVALID, 1'b1);
    ARESET = 1'b1;
    @(negedge clk);
    chk("t6_rst_valids", {AWVALID, WVALID, BREADY, ARVALID, RREADY}, 5'b0);
    chk("t6_rst_flags", {BUSY, DONE, ERROR}, 3'b0);
    chk("t6_rst_err", {ERR_IDX, ERR_CODE}, 10'd0);
    ARESET = 1'b0;
    @(negedge clk);
    clear_mem();
    run_seq(1'b0, cyc, aw_hi);
    chk("t6_latency", cyc, 18);
    check_mem("t6");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
